fetch_unit: RTL

Instruction fetch and program-counter unit for the MIPS CPU, sitting on the consumer side of the control decoder. It owns the PC, issues fetch requests to instruction memory over a req/ack handshake, and holds the fetched word for the decoder and execute logic. When execution signals completion, it computes the next PC from the decoder's `branch`/`jal`/`jr` outputs and the ALU `zero` flag.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/next_pc_sel.sv | 44 ++++
 rtl/fetch_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS CPU definitions: word/field widths, the reset PC and the fetch FSM state type.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int JIDX_W = 26;
  localparam int IMM_W  = 16;

  localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_3000;

  typedef enum logic [1:0] {
    ST_FETCH     = 2'd0,
    ST_WAIT_EXEC = 2'd1,
    ST_ERROR     = 2'd2
  } fetch_state_t;

  function automatic logic word_aligned(input logic [WORD_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: jr > jal/j > taken branch > sequential, plus the target alignment check.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] instr,
  input  logic              branch,
  input  logic              zero,
  input  logic              jal,
  input  logic              jr,
  input  logic [WORD_W-1:0] jr_target,
  output logic [WORD_W-1:0] pc_plus4,
  output logic [WORD_W-1:0] next_pc,
  output logic              target_misaligned
);

  logic [WORD_W-1:0] branch_off_s;
  logic [WORD_W-1:0] branch_target_s;
  logic [WORD_W-1:0] jump_target_s;
  logic [WORD_W-1:0] next_pc_s;

  assign pc_plus4        = pc + 32'd4;
  assign branch_off_s    = {{(WORD_W-IMM_W-2){instr[IMM_W-1]}}, instr[IMM_W-1:0], 2'b00};
  assign branch_target_s = pc_plus4 + branch_off_s;
  assign jump_target_s   = {pc_plus4[WORD_W-1:WORD_W-4], instr[JIDX_W-1:0], 2'b00};

  // Priority mux; jal is also raised for jr, so jr must be tested first.
  always_comb begin
    next_pc_s = pc_plus4;
    if (jr) begin
      next_pc_s = jr_target;
    end else if (jal) begin
      next_pc_s = jump_target_s;
    end else if (branch && zero) begin
      next_pc_s = branch_target_s;
    end else begin
      next_pc_s = pc_plus4;
    end
  end

  assign next_pc           = next_pc_s;
  assign target_misaligned = !word_aligned(next_pc_s);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and PC unit: owns the PC, fetches over req/ack and holds the instruction until execution completes.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus4,
  input  logic              exec_done,
  input  logic              branch,
  input  logic              zero,
  input  logic              jal,
  input  logic              jr,
  input  logic [WORD_W-1:0] jr_target,
  output logic              misaligned
);

  fetch_state_t      state_r;
  logic [WORD_W-1:0] pc_r;
  logic [WORD_W-1:0] instr_r;
  logic              instr_valid_r;
  logic              imem_req_r;
  logic              misaligned_r;

  logic [WORD_W-1:0] pc_plus4_s;
  logic [WORD_W-1:0] next_pc_s;
  logic              target_misaligned_s;

  next_pc_sel u_next_pc_sel (
    .pc                (pc_r),
    .instr             (instr_r),
    .branch            (branch),
    .zero              (zero),
    .jal               (jal),
    .jr                (jr),
    .jr_target         (jr_target),
    .pc_plus4          (pc_plus4_s),
    .next_pc           (next_pc_s),
    .target_misaligned (target_misaligned_s)
  );

  // Fetch FSM; the request is raised one cycle after reset and lowered once the word is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_FETCH;
      pc_r          <= RESET_PC;
      instr_r       <= 32'd0;
      instr_valid_r <= 1'b0;
      imem_req_r    <= 1'b0;
      misaligned_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (!imem_req_r) begin
            imem_req_r <= 1'b1;
          end else if (imem_ack) begin
            instr_r       <= imem_rdata;
            instr_valid_r <= 1'b1;
            imem_req_r    <= 1'b0;
            state_r       <= ST_WAIT_EXEC;
          end else begin
            imem_req_r <= 1'b1;
          end
        end
        ST_WAIT_EXEC: begin
          if (exec_done) begin
            instr_valid_r <= 1'b0;
            if (target_misaligned_s) begin
              misaligned_r <= 1'b1;
              state_r      <= ST_ERROR;
            end else begin
              pc_r       <= next_pc_s;
              imem_req_r <= 1'b1;
              state_r    <= ST_FETCH;
            end
          end else begin
            instr_valid_r <= 1'b1;
          end
        end
        ST_ERROR: begin
          imem_req_r <= 1'b0;
        end
        default: begin
          // Unreachable encoding: park safely with no fetch outstanding.
          imem_req_r    <= 1'b0;
          instr_valid_r <= 1'b0;
          state_r       <= ST_ERROR;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = pc_r;
  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;
  assign pc          = pc_r;
  assign pc_plus4    = pc_plus4_s;
  assign misaligned  = misaligned_r;

endmodule
